// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: load/store initiator for a byte-addressed, 8-byte-wide data
// memory. It accepts one RV64I load/store at a time and aligns it to an 8-byte
// word. It generates byte-lane enables and lane-positioned write data. An access
// that crosses an 8-byte boundary becomes two word accesses when ALLOW_SPLIT=1,
// or completes with an error when ALLOW_SPLIT=0. Load data comes back sign- or
// zero-extended.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req_*           core request (valid/ready, store, funct3, addr, wdata)
//   resp_valid      one-cycle completion pulse
//   resp_err        illegal funct3 or disallowed split (held until next resp)
//   resp_rdata      extended load data, 0 for stores/errors (held)
//   mem_*           word address, lane data, byte enables, write enable, and
//                   combinational read data for mem_addr
//   dbg_state       current FSM state (IDLE=0, ACC_LO=1, ACC_HI=2, RESP=3)
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE. The request fields are registered on that
// edge, so the core may change them afterwards. Responses are never
// back-pressured: resp_valid is a single-cycle pulse.
module lsu_dmem_master #(
  parameter int unsigned ALLOW_SPLIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [63:0] resp_rdata,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_byte_en,
  output logic        mem_wen,
  input  logic [63:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic SPLIT_OK = (ALLOW_SPLIT != 0);

  state_t      state_q, state_d;
  logic [63:0] addr_q;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic [63:0] wdata_q;
  logic [63:0] rd_lo_q;
  logic [63:0] resp_rdata_q;
  logic        resp_err_q;

  // Lanes touched by an access of 2**size bytes starting at byte offset off.
  // Bits [15:8] are the lanes that spill into the next word.
  function automatic logic [15:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] base;
    case (size)
      2'd0:    base = 16'h0001;
      2'd1:    base = 16'h0003;
      2'd2:    base = 16'h000F;
      default: base = 16'h00FF;
    endcase
    return base << off;
  endfunction

  function automatic logic [63:0] extend(input logic [2:0] f3, input logic [63:0] r);
    logic sx;
    sx = ~f3[2];
    case (f3[1:0])
      2'd0:    return {{56{r[7] & sx}}, r[7:0]};
      2'd1:    return {{48{r[15] & sx}}, r[15:0]};
      2'd2:    return {{32{r[31] & sx}}, r[31:0]};
      default: return r;
    endcase
  endfunction

  // Request-side decode, used only to choose the state after acceptance.
  logic [15:0] req_mask;
  logic        req_illegal;
  logic        req_bad;

  assign req_mask    = lane_mask(req_funct3[1:0], req_addr[2:0]);
  assign req_illegal = req_store ? req_funct3[2] : (req_funct3 == 3'b111);
  assign req_bad     = req_illegal | ((|req_mask[15:8]) & ~SPLIT_OK);

  // Registered-request decode that drives the memory port.
  logic [15:0]  mask16;
  logic         crossing;
  logic [127:0] wd128;
  logic [5:0]   sh;
  logic [63:0]  word_addr;

  assign mask16    = lane_mask(funct3_q[1:0], addr_q[2:0]);
  assign crossing  = |mask16[15:8];
  assign sh        = {addr_q[2:0], 3'b000};
  assign wd128     = {64'b0, wdata_q} << sh;
  assign word_addr = {addr_q[63:3], 3'b000};

  // Load assembly: the low word is read in ACC_LO. For a split access it is
  // held in rd_lo_q while the high word arrives in ACC_HI. Shifting the high
  // word left by 64-sh supplies the bytes that spilled past the boundary.
  // When sh is 0 the shift amount is 64, so that term is zero.
  logic [63:0] lo_src;
  logic [63:0] hi_src;
  logic [63:0] aligned;
  logic [63:0] load_data;

  assign lo_src    = (state_q == ACC_HI) ? rd_lo_q : mem_rdata;
  assign hi_src    = (state_q == ACC_HI) ? mem_rdata : 64'd0;
  assign aligned   = (lo_src >> sh) | (hi_src << (7'd64 - {1'b0, sh}));
  assign load_data = store_q ? 64'd0 : extend(funct3_q, aligned);

  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_addr    = 64'd0;
    mem_wdata   = 64'd0;
    mem_byte_en = 8'd0;
    mem_wen     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_bad ? RESP : ACC_LO;
      end
      ACC_LO: begin
        mem_addr    = word_addr;
        mem_byte_en = mask16[7:0];
        mem_wdata   = wd128[63:0];
        mem_wen     = store_q;
        state_d     = crossing ? ACC_HI : RESP;
      end
      ACC_HI: begin
        mem_addr    = word_addr + 64'd8;
        mem_byte_en = mask16[15:8];
        mem_wdata   = wd128[127:64];
        mem_wen     = store_q;
        state_d     = RESP;
      end
      default: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= 64'd0;
      funct3_q     <= 3'd0;
      store_q      <= 1'b0;
      wdata_q      <= 64'd0;
      rd_lo_q      <= 64'd0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            store_q  <= req_store;
            wdata_q  <= req_wdata;
            if (req_bad) begin
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 64'd0;
            end
          end
        end
        ACC_LO: begin
          rd_lo_q <= mem_rdata;
          if (!crossing) begin
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_data;
          end
        end
        ACC_HI: begin
          resp_err_q   <= 1'b0;
          resp_rdata_q <= load_data;
        end
        default: ;
      endcase
    end
  end

  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Bench for lsu_dmem_master. The main instance has ALLOW_SPLIT=1 and sits on a
// 256-byte memory, aliased on the low 8 address bits. A second instance has
// ALLOW_SPLIT=0 and a constant read word. Expected results come from a byte-level
// model of memory plus the RV64I load/store rules.
module tb_lsu_dmem_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        sel_ns = 1'b0;

  logic        a_req_ready, a_resp_valid, a_resp_err;
  logic [63:0] a_resp_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_byte_en;
  logic        mem_wen;
  logic [1:0]  a_dbg_state;

  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [63:0] b_resp_rdata, b_mem_addr, b_mem_wdata;
  logic [7:0]  b_mem_byte_en;
  logic        b_mem_wen;
  logic [1:0]  b_dbg_state;
  logic [63:0] b_mem_rdata = 64'h0123456789ABCDEF;

  lsu_dmem_master #(.ALLOW_SPLIT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel_ns), .req_ready(a_req_ready),
    .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_resp_valid), .resp_err(a_resp_err), .resp_rdata(a_resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
    .mem_wen(mem_wen), .mem_rdata(mem_rdata), .dbg_state(a_dbg_state)
  );

  lsu_dmem_master #(.ALLOW_SPLIT(0)) dut_ns (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel_ns), .req_ready(b_req_ready),
    .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_err(b_resp_err), .resp_rdata(b_resp_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_byte_en(b_mem_byte_en),
    .mem_wen(b_mem_wen), .mem_rdata(b_mem_rdata), .dbg_state(b_dbg_state)
  );

  // Observed signals of whichever instance is under test.
  logic        o_ready, o_valid, o_err, o_wen;
  logic [63:0] o_rdata, o_addr, o_wd;
  logic [7:0]  o_be;
  assign o_ready = sel_ns ? b_req_ready : a_req_ready;
  assign o_valid = sel_ns ? b_resp_valid : a_resp_valid;
  assign o_err   = sel_ns ? b_resp_err : a_resp_err;
  assign o_rdata = sel_ns ? b_resp_rdata : a_resp_rdata;
  assign o_addr  = sel_ns ? b_mem_addr : mem_addr;
  assign o_wd    = sel_ns ? b_mem_wdata : mem_wdata;
  assign o_be    = sel_ns ? b_mem_byte_en : mem_byte_en;
  assign o_wen   = sel_ns ? b_mem_wen : mem_wen;

  // ---------------- memory ----------------
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       init_en = 1'b0;
  logic       poke_en = 1'b0;
  logic [7:0] poke_addr = 8'd0;
  logic [7:0] poke_data = 8'd0;

  always_comb begin
    mem_rdata = 64'd0;
    for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = mem[{mem_addr[7:3], i[2:0]}];
  end

  always @(posedge clk) begin
    if (init_en) for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 29 + 5);
    if (poke_en) mem[poke_addr] <= poke_data;
    if (mem_wen)
      for (int i = 0; i < 8; i++)
        if (mem_byte_en[i]) mem[{mem_addr[7:3], i[2:0]}] <= mem_wdata[8*i +: 8];
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] tr_addr[$];
  logic [63:0] tr_wd[$];
  logic [7:0]  tr_be[$];
  logic        tr_wen[$];

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((mem_wen && mem_byte_en == 8'd0) || (b_mem_wen && b_mem_byte_en == 8'd0)) begin
        errors++;
        $display("FAIL wen_without_lanes got be=%h/%h want nonzero", mem_byte_en, b_mem_byte_en);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int n_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic is_illegal(input logic st, input logic [2:0] f3);
    return st ? f3[2] : (f3 == 3'b111);
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] a, input logic [2:0] f3);
    logic [63:0] v;
    int n;
    v = 64'd0;
    n = n_bytes(f3);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[8'(a + 64'(i))];
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
    return v;
  endfunction

  task automatic model_store(input logic [63:0] a, input logic [2:0] f3, input logic [63:0] wd);
    for (int i = 0; i < n_bytes(f3); i++) ref_mem[8'(a + 64'(i))] = wd[8*i +: 8];
  endtask

  function automatic int model_lat(input logic st, input logic [2:0] f3, input logic [63:0] a);
    if (is_illegal(st, f3)) return 1;
    return (int'(a[2:0]) + n_bytes(f3) > 8) ? 3 : 2;
  endfunction

  // ---------------- drivers ----------------
  // Called just after a rising edge. Returns just after the edge that follows
  // the response cycle. lat counts edges from the accept edge up to the
  // response cycle.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, output int lat, output logic [63:0] rd,
                        output logic er);
    tr_addr.delete(); tr_wd.delete(); tr_be.delete(); tr_wen.delete();
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_idle got %b want 1", o_ready);
    end
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = {$urandom, $urandom};
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_busy got %b want 0", o_ready);
    end
    lat = 1;
    while (o_valid !== 1'b1 && lat < 8) begin
      if (o_be != 8'd0 || o_wen) begin
        tr_addr.push_back(o_addr); tr_wd.push_back(o_wd);
        tr_be.push_back(o_be); tr_wen.push_back(o_wen);
      end
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL resp_timeout got none want resp_valid within 8 cycles");
    end
    checks++;
    if (o_wen !== 1'b0 || o_be !== 8'd0) begin
      errors++;
      $display("FAIL resp_mem_idle got wen=%b be=%h want 0/00", o_wen, o_be);
    end
    rd = o_rdata;
    er = o_err;
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL resp_pulse got valid=%b ready=%b want 0/1", o_valid, o_ready);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0 || a_resp_err !== 1'b0 ||
        a_resp_rdata !== 64'd0 || a_dbg_state !== 2'd0 || b_dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_resp got ready=%b valid=%b err=%b rdata=%h st=%0d/%0d want 1/0/0/0/0/0",
               a_req_ready, a_resp_valid, a_resp_err, a_resp_rdata, a_dbg_state, b_dbg_state);
    end
    checks++;
    if (mem_addr !== 64'd0 || mem_wdata !== 64'd0 || mem_byte_en !== 8'd0 || mem_wen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mem got addr=%h wd=%h be=%h wen=%b want zeros",
               mem_addr, mem_wdata, mem_byte_en, mem_wen);
    end
    init_en = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 29 + 5);
    @(posedge clk); #1;
    init_en = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sd_ld();
    int lat; logic [63:0] rd; logic er;
    do_req(1'b1, 3'b011, 64'h10, 64'h1122334455667788, lat, rd, er);
    model_store(64'h10, 3'b011, 64'h1122334455667788);
    checks++;
    if (lat != 2 || er !== 1'b0 || rd !== 64'd0) begin
      errors++;
      $display("FAIL sd_resp got lat=%0d err=%b rd=%h want 2/0/0", lat, er, rd);
    end
    checks++;
    if (tr_addr.size() != 1 || tr_addr[0] !== 64'h10 || tr_be[0] !== 8'hFF ||
        tr_wen[0] !== 1'b1 || tr_wd[0] !== 64'h1122334455667788) begin
      errors++;
      $display("FAIL sd_access got n=%0d addr=%h be=%h wen=%b wd=%h want 1/10/ff/1/1122334455667788",
               tr_addr.size(), tr_addr[0], tr_be[0], tr_wen[0], tr_wd[0]);
    end
    do_req(1'b0, 3'b011, 64'h10, 64'd0, lat, rd, er);
    checks++;
    if (lat != 2 || er !== 1'b0 || rd !== 64'h1122334455667788) begin
      errors++;
      $display("FAIL ld_resp got lat=%0d err=%b rd=%h want 2/0/1122334455667788", lat, er, rd);
    end
  endtask

  task automatic test_lb();
    int lat; logic [63:0] rd; logic er;
    for (int i = 0; i < 8; i++) poke(8'(8'h18 + i), 8'(8'h80 + i));
    do_req(1'b0, 3'b000, 64'h1B, 64'd0, lat, rd, er);
    checks++;
    if (rd !== 64'hFFFFFFFFFFFFFF83 || er !== 1'b0 || tr_addr.size() != 1 ||
        tr_addr[0] !== 64'h18 || tr_wen[0] !== 1'b0 || tr_be[0] !== 8'h08) begin
      errors++;
      $display("FAIL lb got rd=%h err=%b n=%0d addr=%h be=%h want ffffffffffffff83/0/1/18/08",
               rd, er, tr_addr.size(), tr_addr[0], tr_be[0]);
    end
    do_req(1'b0, 3'b100, 64'h1B, 64'd0, lat, rd, er);
    checks++;
    if (rd !== 64'h83 || er !== 1'b0) begin
      errors++;
      $display("FAIL lbu got rd=%h err=%b want 83/0", rd, er);
    end
  endtask

  task automatic test_split_sw();
    int lat; logic [63:0] rd; logic er;
    do_req(1'b1, 3'b010, 64'h2E, 64'hAABBCCDD, lat, rd, er);
    model_store(64'h2E, 3'b010, 64'hAABBCCDD);
    checks++;
    if (lat != 3 || er !== 1'b0) begin
      errors++;
      $display("FAIL sw_split_lat got lat=%0d err=%b want 3/0", lat, er);
    end
    checks++;
    if (tr_addr.size() != 2 || tr_addr[0] !== 64'h28 || tr_be[0] !== 8'hC0 ||
        tr_wd[0][63:48] !== 16'hCCDD || tr_addr[1] !== 64'h30 || tr_be[1] !== 8'h03 ||
        tr_wd[1][15:0] !== 16'hAABB || tr_wen[0] !== 1'b1 || tr_wen[1] !== 1'b1) begin
      errors++;
      $display("FAIL sw_split_access got n=%0d lo=%h/%h/%h hi=%h/%h/%h want 2 28/c0/ccdd.. 30/03/..aabb",
               tr_addr.size(), tr_addr[0], tr_be[0], tr_wd[0], tr_addr[1], tr_be[1], tr_wd[1]);
    end
    do_req(1'b0, 3'b010, 64'h2E, 64'd0, lat, rd, er);
    checks++;
    if (lat != 3 || rd !== 64'hFFFFFFFFAABBCCDD) begin
      errors++;
      $display("FAIL lw_split got lat=%0d rd=%h want 3/ffffffffaabbccdd", lat, rd);
    end
    do_req(1'b0, 3'b110, 64'h2E, 64'd0, lat, rd, er);
    checks++;
    if (rd !== 64'h00000000AABBCCDD) begin
      errors++;
      $display("FAIL lwu_split got rd=%h want 00000000aabbccdd", rd);
    end
  endtask

  task automatic test_illegal();
    int lat; logic [63:0] rd; logic er;
    do_req(1'b0, 3'b111, 64'h40, 64'd0, lat, rd, er);
    checks++;
    if (lat != 1 || er !== 1'b1 || rd !== 64'd0 || tr_addr.size() != 0) begin
      errors++;
      $display("FAIL load_f3_111 got lat=%0d err=%b rd=%h n=%0d want 1/1/0/0", lat, er, rd, tr_addr.size());
    end
    do_req(1'b1, 3'b100, 64'h48, 64'hDEADBEEFDEADBEEF, lat, rd, er);
    checks++;
    if (lat != 1 || er !== 1'b1 || tr_addr.size() != 0 || mem[8'h48] !== ref_mem[8'h48]) begin
      errors++;
      $display("FAIL store_f3_100 got lat=%0d err=%b n=%0d byte=%h want 1/1/0/%h",
               lat, er, tr_addr.size(), mem[8'h48], ref_mem[8'h48]);
    end
  endtask

  task automatic test_no_split();
    int lat; logic [63:0] rd; logic er;
    sel_ns = 1'b1;
    #1;
    do_req(1'b0, 3'b001, 64'h7, 64'd0, lat, rd, er);
    checks++;
    if (lat != 1 || er !== 1'b1 || rd !== 64'd0 || tr_addr.size() != 0) begin
      errors++;
      $display("FAIL nosplit_lh7 got lat=%0d err=%b rd=%h n=%0d want 1/1/0/0", lat, er, rd, tr_addr.size());
    end
    do_req(1'b0, 3'b001, 64'h6, 64'd0, lat, rd, er);
    checks++;
    if (lat != 2 || er !== 1'b0 || rd !== 64'h0123 || tr_addr.size() != 1 || tr_be[0] !== 8'hC0) begin
      errors++;
      $display("FAIL nosplit_lh6 got lat=%0d err=%b rd=%h n=%0d want 2/0/0123/1", lat, er, rd, tr_addr.size());
    end
    sel_ns = 1'b0;
    #1;
  endtask

  task automatic test_wrap();
    int lat; logic [63:0] rd; logic er; logic [63:0] wd;
    wd = {$urandom, $urandom};
    do_req(1'b1, 3'b011, 64'hFFFFFFFFFFFFFFFC, wd, lat, rd, er);
    model_store(64'hFFFFFFFFFFFFFFFC, 3'b011, wd);
    checks++;
    if (lat != 3 || tr_addr.size() != 2 || tr_addr[0] !== 64'hFFFFFFFFFFFFFFF8 ||
        tr_be[0] !== 8'hF0 || tr_addr[1] !== 64'd0 || tr_be[1] !== 8'h0F) begin
      errors++;
      $display("FAIL wrap_access got lat=%0d n=%0d %h/%h %h/%h want 3/2 fff..f8/f0 0/0f",
               lat, tr_addr.size(), tr_addr[0], tr_be[0], tr_addr[1], tr_be[1]);
    end
    do_req(1'b0, 3'b011, 64'hFFFFFFFFFFFFFFFC, 64'd0, lat, rd, er);
    checks++;
    if (rd !== model_load(64'hFFFFFFFFFFFFFFFC, 3'b011)) begin
      errors++;
      $display("FAIL wrap_load got %h want %h", rd, model_load(64'hFFFFFFFFFFFFFFFC, 3'b011));
    end
  endtask

  task automatic test_random();
    int lat; logic [63:0] rd; logic er;
    logic st; logic [2:0] f3; logic [63:0] a, wd, exp_rd;
    for (int k = 0; k < 80; k++) begin
      st = 1'($urandom_range(0, 1));
      f3 = st ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      wd = {$urandom, $urandom};
      exp_rd = (st || is_illegal(st, f3)) ? 64'd0 : model_load(a, f3);
      do_req(st, f3, a, wd, lat, rd, er);
      if (st && !is_illegal(st, f3)) model_store(a, f3, wd);
      checks++;
      if (lat != model_lat(st, f3, a) || er !== is_illegal(st, f3) || rd !== exp_rd) begin
        errors++;
        $display("FAIL random[%0d] st=%b f3=%0d a=%h got lat=%0d err=%b rd=%h want %0d/%b/%h",
                 k, st, f3, a, lat, er, rd, model_lat(st, f3, a), is_illegal(st, f3), exp_rd);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] wd; int bad;
    wd = 64'h0807060504030201 ^ {$urandom, $urandom};
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b011; req_addr = 64'h3C; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_wen !== 1'b1 || mem_byte_en !== 8'h0F || mem_addr !== 64'h40) begin
      errors++;
      $display("FAIL mid_acc_hi got wen=%b be=%h addr=%h want 1/0f/40", mem_wen, mem_byte_en, mem_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_wen !== 1'b0 || mem_byte_en !== 8'h00 || a_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async got wen=%b be=%h valid=%b want 0/00/0", mem_wen, mem_byte_en, a_resp_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (a_resp_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0 || a_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_after_release got spurious_resp=%0d ready=%b want 0/1", bad, a_req_ready);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem[8'h3C + i] !== wd[8*i +: 8]) bad++;
      if (mem[8'h40 + i] !== ref_mem[8'h40 + i]) bad++;
      ref_mem[8'h3C + i] = wd[8*i +: 8];
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_partial_commit got %0d wrong bytes want 0", bad);
    end
  endtask

  task automatic test_memory_image();
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL memory_image got %0d differing bytes want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_sd_ld();
    test_lb();
    test_split_sw();
    test_illegal();
    test_no_split();
    test_wrap();
    test_random();
    test_reset_mid();
    test_memory_image();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
- Load/store initiator that drives the byte-addressed data memory port: addr, wdata, byte_en, wen, with combinational rdata return and synchronous write.
- Sits between the core's memory stage and the data memory.
- Accepts one RV64I load/store request at a time.
- Aligns it to an 8-byte word, generates byte enables and shifted write data, splits accesses that cross an 8-byte boundary into two word accesses, and returns sign/zero-extended load data.

Parameters:
- ALLOW_SPLIT, 1, 1 = boundary-crossing accesses are split into two word accesses; 0 = they complete with resp_err and no memory access.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  core request valid
- req_ready  output  1  block can accept a request
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV64I funct3: loads 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; stores 000 SB to 011 SD
- req_addr  input  64  byte address
- req_wdata  input  64  store data, right-justified
- resp_valid  output  1  one-cycle completion pulse
- resp_err  output  1  valid with resp_valid; illegal funct3 or disallowed split
- resp_rdata  output  64  extended load data; 0 for stores/errors
- mem_addr  output  64  8-byte-aligned word address
- mem_wdata  output  64  lane-positioned write data
- mem_byte_en  output  8  byte lane enables
- mem_wen  output  1  write enable
- mem_rdata  input  64  combinational read data for mem_addr

Behaviour:
- Reset: state IDLE. req_ready=1. resp_valid=0, resp_err=0, resp_rdata=0. mem_addr=0, mem_wdata=0, mem_byte_en=0, mem_wen=0. All internal request registers cleared.
- Memory outputs are decoded from registered state only; no combinational path from req_* to mem_*.
- States: IDLE, ACC_LO, ACC_HI, RESP.
- IDLE: req_ready=1. On req_valid, register addr/funct3/store/wdata.
  - Illegal funct3 (load 111; store funct3[2]=1) goes to RESP with err=1.
  - Crossing with ALLOW_SPLIT=0 goes to RESP with err=1.
  - Otherwise goes to ACC_LO.
- Size n = 1/2/4/8 bytes from funct3[1:0]. off = addr[2:0].
  - mask16 = ((1<<n)-1) << off.
  - lo_en = mask16[7:0], hi_en = mask16[15:8].
  - crossing = (hi_en != 0).
- Shifted data: wd128 = {64'b0, wdata} << (8*off).
- ACC_LO:
  - mem_addr = {addr[63:3], 3'b000}, mem_byte_en = lo_en, mem_wdata = wd128[63:0], mem_wen = store.
  - Capture mem_rdata into rd_lo at the end of the cycle.
  - Next state is ACC_HI if crossing, else RESP.
- ACC_HI:
  - mem_addr = {addr[63:3], 3'b000} + 8 (64-bit wrap at top of space), mem_byte_en = hi_en, mem_wdata = wd128[127:64], mem_wen = store.
  - Capture rd_hi. Next state RESP.
- rd_hi = 0 when no split.
- Load result: r = ({rd_hi, rd_lo} >> (8*off))[63:0]. Keep the low n bytes; sign-extend if funct3[2]=0, zero-extend otherwise.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0, mem_wen=0, mem_byte_en=0. Next state IDLE.
- resp_rdata/resp_err hold their value until the next RESP. No response backpressure.
- req_ready=0 in ACC_LO, ACC_HI, RESP.
- Latency from accept edge to resp_valid:
  - Non-split: 2 cycles.
  - Split: 3 cycles.
  - Error: 1 cycle.
- Back-to-back throughput: one request per 3 (non-split) or 4 (split) cycles.
- mem_wen is never asserted with mem_byte_en=0.
- mem_wen is never asserted outside ACC_LO/ACC_HI.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously) and no response is issued. A split store reset during ACC_HI leaves only the low half committed; this is the required behaviour.

Test Plan:
- SD addr 0x10, wdata 0x1122334455667788: accept edge T, ACC_LO at T+1 with mem_addr=0x10, byte_en=0xFF, wen=1. resp_valid at T+2, err=0. A following LD 0x10 returns 0x1122334455667788.
- Memory bytes 0x18..0x1F = 80 81..87, LB 0x1B: mem_addr=0x18 → resp_rdata=0xFFFFFFFFFFFFFF83. LBU 0x1B → 0x83.
- SW addr 0x2E, wdata 0xAABBCCDD (split): ACC_LO has mem_addr=0x28, byte_en=0xC0, wdata[63:48]=0xCCDD. ACC_HI has mem_addr=0x30, byte_en=0x03, wdata[15:0]=0xAABB. resp_valid at T+3. LW 0x2E → 0xFFFFFFFFAABBCCDD; LWU 0x2E → 0x00000000AABBCCDD.
- ALLOW_SPLIT=0, LH addr 0x7: resp_valid at T+1, resp_err=1, mem_wen and byte_en stay 0 throughout.
- Load funct3=111: resp_err=1 after 1 cycle. Store funct3=100: resp_err=1, no memory write.
- Split SD addr 0x3C, rst asserted during ACC_HI: mem_wen drops the same cycle, no resp_valid, bytes 0x3C..0x3F written, bytes 0x40..0x43 unchanged. After release, req_ready=1.
